axi4_ram: RTL and testbench
===========================

Name: axi4_ram

Overview:
- Behavioural AXI4 slave RAM used as instruction memory and external data memory beside the ariane_single_core SoC in simulation.
- Accepts full AXI4 read and write bursts on independent channels and stores data in a word-addressed internal array.
- The array is preloadable by $readmemh through the hierarchical path <inst>.mem.

Parameters:
- DATA_WIDTH, 64: data bus width in bits. Must be a power of two and at least 8.
- ADDR_WIDTH, 64: AXI address width.
- ID_WIDTH, 4: AXI ID width. Always overridden with the SoC ID width.
- MEM_ADDR_WIDTH, 18: number of byte-address bits decoded (2^18 bytes = 256 KiB).

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  write address channel.
- s_axi_awvalid  in  1 / s_axi_awready  out  1.
- s_axi_wdata  in  DATA_WIDTH / s_axi_wstrb  in  DATA_WIDTH/8 / s_axi_wlast  in  1 / s_axi_wvalid  in  1 / s_axi_wready  out  1.
- s_axi_bid  out  ID_WIDTH / s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  read address channel.
- s_axi_arvalid  in  1 / s_axi_arready  out  1.
- s_axi_rid  out  ID_WIDTH / s_axi_rdata  out  DATA_WIDTH / s_axi_rresp  out  2 / s_axi_rlast  out  1 / s_axi_rvalid  out  1 / s_axi_rready  in  1.

Behaviour:
Storage:
- Array mem[0 : 2^(MEM_ADDR_WIDTH-LSB)-1], each entry DATA_WIDTH bits, where LSB = log2(DATA_WIDTH/8) (3 for 64-bit).
- Word index = addr[MEM_ADDR_WIDTH-1:LSB]. Address bits above MEM_ADDR_WIDTH are ignored, so accesses alias.
- Contents are not touched by reset.

Fixed protocol choices:
- awlock, awcache, awprot, arlock, arcache, arprot are ignored.
- bresp and rresp are always 2'b00 (OKAY).

Address sequencing, same for both channels:
- FIXED (0): address held for every beat.
- INCR (1): address += 1<<size per beat.
- WRAP (2): address increments as INCR, then wraps within the aligned block of (len+1)<<size bytes.
- Burst type 3 is treated as INCR.
- A new word is selected whenever the index bits change.

Write FSM:
- States are W_IDLE, W_DATA and W_RESP.
- Reset: state W_IDLE, awready=0, wready=0, bvalid=0, bid=0.
- W_IDLE: awready=1. On awvalid&&awready, latch id, addr, len, size and burst, set beat count to 0, go to W_DATA.
- W_DATA: awready=0, wready=1. Each wvalid&&wready beat writes every byte lane whose wstrb bit is set into mem[index]; other lanes are unchanged. Then the address advances.
- W_DATA exit: the beat where count==len goes to W_RESP. s_axi_wlast is not used for termination.
- W_RESP: wready=0, bvalid=1, bid = latched id. On bready, go to W_IDLE.
- The B response appears the cycle after the last W beat.

Read FSM:
- States are R_IDLE and R_DATA.
- Reset: state R_IDLE, arready=0, rvalid=0, rlast=0, rid=0, rdata=0.
- R_IDLE: arready=1. If arvalid&&arready at edge T, latch id, len, size and burst. The first beat presents rvalid=1 with rdata = mem[araddr index] registered at edge T, visible after T.
- R_DATA: rlast=1 when beat count==len.
- On rvalid&&rready on a non-last beat, load the next address's data and keep rvalid=1, giving one beat per cycle under continuous rready.
- When rready is low, rdata, rid and rlast hold stable.
- On the last handshake: rvalid=0, then R_IDLE with arready=1 from the next cycle.

Concurrency:
- Read and write channels are fully independent and may run at once.
- If a read word is loaded on the same edge that a write updates that word, the read returns the pre-write value.

Reset:
- Reset asserted mid-burst aborts both FSMs to idle with all valid and ready outputs low.
- A burst in progress is dropped with no response.
- Memory writes already performed remain.

Test Plan:
1. Preload mem[0x200]=0x0000_0013_0000_0297. Single read araddr=0x1000, len=0, rready=1 -> rvalid one cycle after the AR handshake, rdata=0x0000001300000297, rlast=1, rid=arid, rresp=0.
2. INCR write, awaddr=0x2000, len=3, size=3, data 0x11..,0x22..,0x33..,0x44.., wstrb=0xFF -> bvalid one cycle after the 4th beat, bid=awid, bresp=0. INCR read of the same range returns the same 4 words with rlast only on beat 4.
3. Write 0xAABBCCDD_EEFF0011 to 0x3000 with wstrb=0xFF, then 0x0 with wstrb=0x0F -> read gives 0xAABBCCDD_00000000.
4. WRAP read, araddr=0x4010, len=3, size=3, with mem[0x800..0x803]=0,1,2,3 -> data order 2,3,0,1. FIXED read len=2 at 0x4000 -> 0,0,0.
5. rready toggled 1,0,0,1 during a 4-beat read -> rdata and rlast stable while stalled, no beat lost. Simultaneous write burst on the other channel completes correctly.
6. rst_n low for one cycle in the middle of a write burst -> awready, wready, bvalid and rvalid are all 0 the next cycle. A later fresh write/read to 0x40000 aliases to word 0 (index wrap).

Source files
------------

// File: rtl/axi4_ram.sv
// Behavioural AXI4 slave RAM: independent read/write burst engines over a word array.
// The array mem is left unreset so it can be preloaded externally through its hierarchical path.
module axi4_ram #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_ADDR_WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = MEM_ADDR_WIDTH - LSB;
  localparam int DEPTH  = 1 << IDX_W;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // FIXED holds, WRAP stays inside the (len+1)<<size block, INCR and reserved type 3 increment.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] one;
    logic [ADDR_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] wmask;
    one   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    sum   = a + (one << size);
    wmask = (({{(ADDR_WIDTH-8){1'b0}}, len} + one) << size) - one;
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~wmask) | (sum & wmask);
      default: next_addr = sum;
    endcase
  endfunction

  logic unused_inputs_s;
  assign unused_inputs_s = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot};

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d, bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                  mem_we_s;
  logic [IDX_W-1:0]      aw_idx_s;

  assign aw_idx_s = aw_addr_q[MEM_ADDR_WIDTH-1:LSB];

  // Write FSM next state; handshake outputs are registered copies of the next state.
  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    bid_d      = bid_q;
    mem_we_s   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          aw_id_d    = s_axi_awid;
          aw_addr_d  = s_axi_awaddr;
          aw_len_d   = s_axi_awlen;
          aw_size_d  = s_axi_awsize;
          aw_burst_d = s_axi_awburst;
          w_cnt_d    = 8'd0;
          w_state_d  = W_DATA;
        end else begin
          w_state_d  = W_IDLE;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we_s  = rst_n;
          aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
          w_cnt_d   = w_cnt_q + 8'd1;
          if (w_cnt_q == aw_len_q) begin
            w_state_d = W_RESP;
            bid_d     = aw_id_q;
          end else begin
            w_state_d = W_DATA;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (s_axi_bready && bvalid_q) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write FSM state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= 8'd0;
      aw_size_q  <= 3'd0;
      aw_burst_q <= 2'd0;
      w_cnt_q    <= 8'd0;
      bid_q      <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      bid_q      <= bid_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
    end
  end

  // Byte-lane write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[aw_idx_s][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_load_s;
  logic [IDX_W-1:0]      rd_idx_s;

  // Read FSM: r_addr_q always points at the word to load on the next accepted beat.
  always_comb begin
    r_state_d  = r_state_q;
    rid_d      = rid_q;
    r_addr_d   = r_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    rlast_d    = rlast_q;
    rd_load_s  = 1'b0;
    rd_idx_s   = r_addr_q[MEM_ADDR_WIDTH-1:LSB];
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          rid_d      = s_axi_arid;
          ar_len_d   = s_axi_arlen;
          ar_size_d  = s_axi_arsize;
          ar_burst_d = s_axi_arburst;
          r_addr_d   = next_addr(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
          r_cnt_d    = 8'd0;
          rlast_d    = (s_axi_arlen == 8'd0);
          rd_load_s  = 1'b1;
          rd_idx_s   = s_axi_araddr[MEM_ADDR_WIDTH-1:LSB];
          r_state_d  = R_DATA;
        end else begin
          r_state_d  = R_IDLE;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            rd_load_s = 1'b1;
            r_addr_d  = next_addr(r_addr_q, ar_len_q, ar_size_q, ar_burst_q);
            r_cnt_d   = r_cnt_q + 8'd1;
            rlast_d   = ((r_cnt_q + 8'd1) == ar_len_q);
            r_state_d = R_DATA;
          end
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // Read FSM state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      rid_q      <= '0;
      r_addr_q   <= '0;
      ar_len_q   <= 8'd0;
      ar_size_q  <= 3'd0;
      ar_burst_q <= 2'd0;
      r_cnt_q    <= 8'd0;
      rlast_q    <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      rid_q      <= rid_d;
      r_addr_q   <= r_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
      rlast_q    <= rlast_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Read data register; a same-edge write is not forwarded, so the old word is returned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_load_s) begin
      rdata_q <= mem[rd_idx_s];
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
endmodule

// File: tb/tb_axi4_ram.sv
// Self-checking bench for axi4_ram: scoreboard queues hold expected R data and B ids.
module tb_axi4_ram;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awid, arid, bid, rid;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q [$];
  logic [3:0]  bid_q [$];
  logic [63:0] wtab [4];

  axi4_ram dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write burst (nsend < len+1 leaves it unfinished); B response checked on completion.
  task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input logic [7:0] strb, input int nsend);
    int cyc;
    logic hs;
    logic [3:0] eid;
    awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awid = id; awvalid = 1'b1;
    if (nsend > int'(len)) bid_q.push_back(id);
    cyc = 0;
    do begin hs = awready; step(); cyc++; end while (!hs && cyc < 50);
    awvalid = 1'b0;
    n_checks++;
    if (!hs) begin n_fail++; $display("FAIL aw_handshake: awready never seen, want 1"); end
    for (int b = 0; b < nsend; b++) begin
      wdata = wtab[b]; wstrb = strb; wlast = (b == int'(len)); wvalid = 1'b1;
      cyc = 0;
      do begin hs = wready; step(); cyc++; end while (!hs && cyc < 50);
      n_checks++;
      if (!hs) begin n_fail++; $display("FAIL w_handshake: beat %0d wready never seen", b); end
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (nsend > int'(len)) begin
      eid = (bid_q.size() > 0) ? bid_q.pop_front() : 4'hx;
      n_checks++;
      if (bvalid !== 1'b1 || bid !== eid || bresp !== 2'b00) begin
        n_fail++;
        $display("FAIL b_resp: bvalid=%b bid=%h bresp=%b, want 1 %h 00", bvalid, bid, bresp, eid);
      end
      step();
      n_checks++;
      if (bvalid !== 1'b0) begin n_fail++; $display("FAIL b_done: bvalid=%b want 0", bvalid); end
    end
  endtask

  // Read burst; rready follows pat (bit = cycle), stalled beats must hold steady.
  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input logic [15:0] pat);
    int cyc, beat;
    logic hs, stalled, s_last;
    logic [63:0] s_data, e;
    araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arid = id; arvalid = 1'b1;
    cyc = 0;
    do begin hs = arready; step(); cyc++; end while (!hs && cyc < 50);
    arvalid = 1'b0;
    n_checks++;
    if (!hs || rvalid !== 1'b1) begin
      n_fail++; $display("FAIL r_first: rvalid=%b one cycle after AR, want 1", rvalid);
    end
    beat = 0; cyc = 0; stalled = 1'b0; s_data = '0; s_last = 1'b0;
    while (beat <= int'(len) && cyc < 100) begin
      rready = pat[cyc % 16];
      if (rvalid === 1'b1) begin
        if (rready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
          n_checks++;
          if (rdata !== e || rlast !== (beat == int'(len)) || rid !== id || rresp !== 2'b00) begin
            n_fail++;
            $display("FAIL r_beat%0d: rdata=%h rlast=%b rid=%h rresp=%b, want %h %b %h 00",
                     beat, rdata, rlast, rid, rresp, e, (beat == int'(len)), id);
          end
          beat++;
        end else begin
          stalled = 1'b1; s_data = rdata; s_last = rlast;
        end
      end
      step(); cyc++;
      if (stalled) begin
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== s_data || rlast !== s_last) begin
          n_fail++;
          $display("FAIL r_stall: rvalid=%b rdata=%h rlast=%b, want 1 %h %b",
                   rvalid, rdata, rlast, s_data, s_last);
        end
        stalled = 1'b0;
      end
    end
    rready = 1'b1;
    n_checks++;
    if (beat <= int'(len) || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL r_end: beats=%0d rvalid=%b, want %0d 0", beat, rvalid, len + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 || bid !== 4'd0 ||
        rid !== 4'd0 || rdata !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: aw/w/b/ar/rv/rl=%b bid=%h rid=%h rdata=%h, want 0",
               {awready, wready, bvalid, arready, rvalid, rlast}, bid, rid, rdata);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: awready=%b arready=%b, want 1 1", awready, arready);
    end
  endtask

  task automatic test_single_read();
    wtab[0] = 64'h0000_0013_0000_0297;
    axi_write(64'h1000, 8'd0, 2'd1, 4'h1, 8'hFF, 1);
    exp_q.push_back(64'h0000_0013_0000_0297);
    axi_read(64'h1000, 8'd0, 2'd1, 4'h5, 16'hFFFF);
  endtask

  task automatic test_incr();
    wtab = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    axi_write(64'h2000, 8'd3, 2'd1, 4'hA, 8'hFF, 4);
    for (int i = 0; i < 4; i++) exp_q.push_back(wtab[i]);
    axi_read(64'h2000, 8'd3, 2'd1, 4'h3, 16'hFFFF);
  endtask

  task automatic test_strobe();
    wtab[0] = 64'hAABB_CCDD_EEFF_0011;
    axi_write(64'h3000, 8'd0, 2'd1, 4'h2, 8'hFF, 1);
    wtab[0] = 64'h0;
    axi_write(64'h3000, 8'd0, 2'd1, 4'h2, 8'h0F, 1);
    exp_q.push_back(64'hAABB_CCDD_0000_0000);
    axi_read(64'h3000, 8'd0, 2'd1, 4'h6, 16'hFFFF);
  endtask

  task automatic test_wrap_fixed();
    wtab = '{64'd0, 64'd1, 64'd2, 64'd3};
    axi_write(64'h4000, 8'd3, 2'd1, 4'h4, 8'hFF, 4);
    exp_q.push_back(64'd2); exp_q.push_back(64'd3);
    exp_q.push_back(64'd0); exp_q.push_back(64'd1);
    axi_read(64'h4010, 8'd3, 2'd2, 4'h7, 16'hFFFF);
    for (int i = 0; i < 3; i++) exp_q.push_back(64'd0);
    axi_read(64'h4000, 8'd2, 2'd0, 4'h8, 16'hFFFF);
    exp_q.push_back(64'd1); exp_q.push_back(64'd2);
    axi_read(64'h4008, 8'd1, 2'd3, 4'h9, 16'hFFFF);
  endtask

  task automatic test_stall_concurrent();
    wtab = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    axi_write(64'h6000, 8'd3, 2'd1, 4'h1, 8'hFF, 4);
    for (int i = 0; i < 4; i++) exp_q.push_back(64'hA0 + 64'(i));
    wtab = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
    fork
      axi_read(64'h6000, 8'd3, 2'd1, 4'hC, 16'b1111_1111_1111_1001);
      axi_write(64'h7000, 8'd3, 2'd1, 4'hD, 8'hFF, 4);
    join
    for (int i = 0; i < 4; i++) exp_q.push_back(64'hB0 + 64'(i));
    axi_read(64'h7000, 8'd3, 2'd1, 4'hE, 16'hFFFF);
  endtask

  task automatic test_reset_mid_burst();
    wtab = '{64'hC0, 64'hC1, 64'hC2, 64'hC3};
    axi_write(64'h5000, 8'd3, 2'd1, 4'hF, 8'hFF, 2);
    rst_n = 1'b0;
    step();
    n_checks++;
    if ({awready, wready, bvalid, rvalid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_mid: aw/w/b/rv=%b, want 0000", {awready, wready, bvalid, rvalid});
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      n_fail++; $display("FAIL reset_drop: bvalid=%b awready=%b, want 0 1", bvalid, awready);
    end
    exp_q.push_back(64'hC0); exp_q.push_back(64'hC1);
    axi_read(64'h5000, 8'd1, 2'd1, 4'h2, 16'hFFFF);
    wtab[0] = 64'hDEAD_BEEF_0123_4567;
    axi_write(64'h40000, 8'd0, 2'd1, 4'h3, 8'hFF, 1);
    exp_q.push_back(64'hDEAD_BEEF_0123_4567);
    axi_read(64'h0, 8'd0, 2'd1, 4'h4, 16'hFFFF);
    exp_q.push_back(64'hDEAD_BEEF_0123_4567);
    axi_read(64'h40000, 8'd0, 2'd1, 4'h5, 16'hFFFF);
  endtask

  initial begin
    awid = 4'd0; awaddr = '0; awlen = 8'd0; awsize = 3'd3; awburst = 2'd1; awvalid = 1'b0;
    wdata = '0; wstrb = 8'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = 4'd0; araddr = '0; arlen = 8'd0; arsize = 3'd3; arburst = 2'd1; arvalid = 1'b0;
    rready = 1'b1;
    test_reset();
    test_single_read();
    test_incr();
    test_strobe();
    test_wrap_fixed();
    test_stall_concurrent();
    test_reset_mid_burst();
    n_checks++;
    if (exp_q.size() != 0 || bid_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: r=%0d b=%0d left, want 0 0", exp_q.size(), bid_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
